program_loader: RTL
===================

// Module: program_loader
// PURPOSE
//  Boot-time front end of the pipelined CPU. It collects a program from a host over a valid/ready
//  stream into a local buffer. It then replays the buffer into the CPU instruction-memory load port
//  as one contiguous burst, one word per clk, because the CPU load-address counter advances every
//  cycle and cannot be stalled. Finally it holds the CPU in reset so PC and IF/ID restart at 0,
//  then releases it to run.
// PARAMETERS
//  WORD_W   32  instruction width
//  DEPTH    32  program buffer depth in words; power of 2; matches CPU instruction memory
//  RST_CYC  2   cycles cpu_reset is held after the burst; must be >= 1
// PORTS
//  clk         in   1                  system clock, rising edge
//  Reset       in   1                  asynchronous, active-high reset
//  in_valid    in   1                  host word valid
//  in_data     in   WORD_W             host instruction word
//  in_last     in   1                  marks final word of the program
//  in_ready    out  1                  loader accepts a word this cycle
//  reload      in   1                  pulse in RUN: return to IDLE for a new program
//  cpu_reset   out  1                  drives CPU Reset
//  cpu_load    out  1                  drives CPU LoadInstructions
//  cpu_instr   out  WORD_W             drives CPU Instruction
//  busy        out  1                  high in FILL, BURST, POST_RST
//  done        out  1                  high in RUN
//  word_count  out  $clog2(DEPTH)+1    number of words in the current program
// BEHAVIOUR
//  Reset values (asynchronous, all outputs registered): state=IDLE, cpu_reset=1, cpu_load=0,
//   cpu_instr=0, in_ready=1, busy=0, done=0, word_count=0.
//  States:
//   IDLE      in_ready=1, cpu_reset=1. An accepted word is written to buf[0] and word_count=1.
//             If that word has in_last, go to BURST; otherwise go to FILL.
//   FILL      in_ready=1, cpu_reset=1. Each accepted word goes to buf[word_count], then
//             word_count increments. Leave for BURST on an accepted word with in_last, or when
//             word_count reaches DEPTH. At DEPTH, in_ready drops on the following cycle and no
//             further words are accepted.
//   BURST     in_ready=0. For k=0..word_count-1 the outputs are cpu_reset=0, cpu_load=1,
//             cpu_instr=buf[k], each on consecutive cycles with no gaps. The first burst cycle
//             follows the transfer of the final accepted word by exactly 1 clk. cpu_load and
//             cpu_instr change together and the burst is never interrupted.
//   POST_RST  cpu_load=0, cpu_instr=0, cpu_reset=1 for exactly RST_CYC cycles, then go to RUN.
//   RUN       cpu_reset=0, done=1, in_ready=0. Stay here until reload=1, then go to IDLE with
//             cpu_reset=1 on the next cycle and word_count=0.
//  Handshake: a transfer occurs on a cycle where in_valid && in_ready. in_data is sampled only
//   on a transfer. in_ready does not depend combinationally on in_valid.
//  Boundary rules:
//   - A minimum program is one word (in_last on the first transfer). Zero-length is impossible.
//   - When the DEPTH-th word arrives without in_last, it is treated as last; no error is raised.
//   - reload outside RUN is ignored. in_valid outside IDLE/FILL is ignored.
//   - Reset asserted mid-BURST or mid-POST_RST: asynchronous return to IDLE. cpu_reset=1 and
//     cpu_load=0 immediately. Buffer contents are don't-care.
//   - cpu_reset is high in every state except BURST and RUN, so the CPU never runs a partial
//     program.
// STRUCTURE
//  Shared include loader_defs.vh: state encodings LDR_IDLE, LDR_FILL, LDR_BURST, LDR_POST_RST,
//   LDR_RUN (3-bit localparams); the function clog2.
//  Sub-module loader_buf: DEPTH x WORD_W storage with one synchronous write port and an
//   asynchronous read port. No reset on storage. The top level holds the FSM, the write/read
//   pointers and the RST_CYC counter, and registers the outputs.
// TESTING
//  1 Reset: hold Reset for 3 cycles -> cpu_reset=1, cpu_load=0, in_ready=1, word_count=0;
//    all outputs stay at reset values.
//  2 Basic load: send 4 words 0x20010005, 0x20020003, 0x00221820, 0xAC030000, the last with
//    in_last -> cpu_load=1 for exactly 4 consecutive cycles carrying those words in order ->
//    cpu_reset=1 for 2 cycles -> done=1. Bench also checks CPU `out` after RUN shows $3=8.
//  3 Single word: one transfer with in_last=1 -> a 1-cycle burst with word_count=1, then
//    POST_RST, then RUN.
//  4 Overflow: 33 words with in_valid held high and no in_last -> only 32 transfers occur,
//    in_ready falls, and a 32-cycle burst follows.
//  5 Backpressure: random in_valid gaps during FILL -> the burst is still gap-free and its
//    contents match the sent order.
//  6 Reset mid-burst at burst cycle 2 of 4 -> cpu_load=0 and cpu_reset=1 asynchronously;
//    reload of a new 2-word program then completes correctly.
//    reload pulse in RUN -> IDLE, cpu_reset=1, word_count=0.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared types for the boot-time program loader: FSM state encoding and a constant log2 helper.
package program_loader_pkg;

  typedef enum logic [2:0] {
    LDR_IDLE     = 3'd0,
    LDR_FILL     = 3'd1,
    LDR_BURST    = 3'd2,
    LDR_POST_RST = 3'd3,
    LDR_RUN      = 3'd4
  } ldrState_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/program_loader_buf.sv
// Program buffer: one synchronous write port, one asynchronous read port, no storage reset.
module program_loader_buf #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 32,
  parameter int AW     = 5
) (
  input  logic              clk,
  input  logic              wrEn,
  input  logic [AW-1:0]     wrAddr,
  input  logic [WORD_W-1:0] wrData,
  input  logic [AW-1:0]     rdAddr,
  output logic [WORD_W-1:0] rdData
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= wrData;
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/program_loader.sv
// Collects a host program into a buffer, replays it to the CPU load port as one gap-free burst,
// then holds the CPU in reset for RST_CYC cycles before letting it run.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int WORD_W  = 32,
  parameter int DEPTH   = 32,
  parameter int RST_CYC = 2
) (
  input  logic                        clk,
  input  logic                        Reset,
  input  logic                        in_valid,
  input  logic [WORD_W-1:0]           in_data,
  input  logic                        in_last,
  output logic                        in_ready,
  input  logic                        reload,
  output logic                        cpu_reset,
  output logic                        cpu_load,
  output logic [WORD_W-1:0]           cpu_instr,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(DEPTH):0]      word_count
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = (clog2(RST_CYC + 1) > 0) ? clog2(RST_CYC + 1) : 1;

  ldrState_e         state;
  logic [CW-1:0]     rdPtr;
  logic [RW-1:0]     rstCnt;
  logic [WORD_W-1:0] rdData;
  logic [WORD_W-1:0] firstWord;
  logic [CW-1:0]     nextCount;
  logic              xfer;
  logic              lastXfer;

  assign xfer      = in_valid && in_ready;
  assign nextCount = word_count + 1'b1;
  // A full buffer counts as the end of the program even without in_last.
  assign lastXfer  = in_last || (nextCount == CW'(DEPTH));
  // In IDLE buf[0] is written on the same edge the burst starts, so bypass the array.
  assign firstWord = (state == LDR_IDLE) ? in_data : rdData;

  program_loader_buf #(.WORD_W(WORD_W), .DEPTH(DEPTH), .AW(AW)) u_buf (
    .clk    (clk),
    .wrEn   (xfer),
    .wrAddr (word_count[AW-1:0]),
    .wrData (in_data),
    .rdAddr (rdPtr[AW-1:0]),
    .rdData (rdData)
  );

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state      <= LDR_IDLE;
      rdPtr      <= '0;
      rstCnt     <= '0;
      word_count <= '0;
      in_ready   <= 1'b1;
      cpu_reset  <= 1'b1;
      cpu_load   <= 1'b0;
      cpu_instr  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        LDR_IDLE, LDR_FILL: begin
          if (xfer) begin
            word_count <= nextCount;
            busy       <= 1'b1;
            if (lastXfer) begin
              state     <= LDR_BURST;
              in_ready  <= 1'b0;
              cpu_reset <= 1'b0;
              cpu_load  <= 1'b1;
              cpu_instr <= firstWord;
              rdPtr     <= CW'(1);
            end else begin
              state <= LDR_FILL;
            end
          end
        end
        LDR_BURST: begin
          if (rdPtr == word_count) begin
            state     <= LDR_POST_RST;
            cpu_load  <= 1'b0;
            cpu_instr <= '0;
            cpu_reset <= 1'b1;
            rstCnt    <= RW'(RST_CYC - 1);
            rdPtr     <= '0;
          end else begin
            cpu_instr <= rdData;
            rdPtr     <= rdPtr + 1'b1;
          end
        end
        LDR_POST_RST: begin
          if (rstCnt == '0) begin
            state     <= LDR_RUN;
            cpu_reset <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            rstCnt <= rstCnt - 1'b1;
          end
        end
        LDR_RUN: begin
          if (reload) begin
            state      <= LDR_IDLE;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            in_ready   <= 1'b1;
            word_count <= '0;
          end
        end
        default: state <= LDR_IDLE;
      endcase
    end
  end

endmodule
